// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit that sits beside the EX-stage ALU.
package mul_div_unit_pkg;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

   function automatic int md_cnt_w(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

   function automatic logic md_is_signed(input md_op_e op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

   function automatic logic md_is_div(input md_op_e op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/mul_div_unit_div_core.sv
// Restoring radix-2 divider datapath on operand magnitudes; one quotient bit per enabled cycle.
module mul_div_unit_div_core #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quo_next,
   output logic [WIDTH-1:0] rem_next
);

   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH:0]   shifted;
   logic             fits;

   // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latch).
   always_comb begin
      // The shifted partial remainder can reach 2*divisor-1, hence the extra bit for the compare.
      shifted  = {rem_q, quo_q[WIDTH-1]};
      fits     = (shifted >= {1'b0, dvs_q});
      rem_next = fits ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
      quo_next = {quo_q[WIDTH-2:0], fits};

      rem_d = rem_q;
      quo_d = quo_q;
      dvs_d = dvs_q;
      if (load) begin
         rem_d = '0;
         quo_d = dividend;
         dvs_d = divisor;
      end else if (en) begin
         rem_d = rem_next;
         quo_d = quo_next;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
      end else begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         dvs_q <= dvs_d;
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with start/busy/done handshake and one HI/LO write per op.
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MUL_ITER = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             cancel,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             busy,
   output logic             done,
   output logic             we_hi,
   output logic             we_lo,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             div_by_zero
);

   localparam int               CNT_W    = md_cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   md_state_e        state_q, state_d;
   md_op_e           op_in, op_q, op_d;
   logic             sa_q, sa_d, sb_q, sb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mul_hi_q, mul_hi_d, mul_lo_q, mul_lo_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic             dbz_q, dbz_d;

   logic               in_signed, in_div, in_dbz, launch;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [2*WIDTH-1:0] fast_prod, fast_res, prod_res;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH-1:0]   mul_hi_step, mul_lo_step;
   logic               div_load, div_en, quo_neg, rem_neg;
   logic [WIDTH-1:0]   div_quo, div_rem;

   assign op_in = md_op_e'(op);

   always_comb begin : operand_prep
      in_signed = md_is_signed(op_in);
      in_div    = md_is_div(op_in);
      in_dbz    = in_div && (src_b == '0);
      a_mag     = (in_signed && src_a[WIDTH-1]) ? -src_a : src_a;
      b_mag     = (in_signed && src_b[WIDTH-1]) ? -src_b : src_b;
      fast_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
      fast_res  = (in_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1])) ? -fast_prod : fast_prod;
   end

   // Shift-add step: add the multiplicand on a set multiplier bit, then shift {carry,hi,lo} right.
   always_comb begin : mul_step
      mul_sum     = {1'b0, mul_hi_q} + (mul_lo_q[0] ? {1'b0, mcand_q} : '0);
      mul_hi_step = mul_sum[WIDTH:1];
      mul_lo_step = {mul_sum[0], mul_lo_q[WIDTH-1:1]};
   end

   always_comb begin : sign_fix
      quo_neg  = md_is_signed(op_q) && (sa_q ^ sb_q);
      rem_neg  = md_is_signed(op_q) && sa_q;
      prod_res = quo_neg ? -{mul_hi_step, mul_lo_step} : {mul_hi_step, mul_lo_step};
   end

   mul_div_unit_div_core #(
      .WIDTH(WIDTH)
   ) u_div_core (
      .clk      (clk),
      .rst      (rst),
      .load     (div_load),
      .en       (div_en),
      .dividend (a_mag),
      .divisor  (b_mag),
      .quo_next (div_quo),
      .rem_next (div_rem)
   );

   always_comb begin : fsm_next
      state_d  = state_q;
      op_d     = op_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mul_hi_d = mul_hi_q;
      mul_lo_d = mul_lo_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      dbz_d    = 1'b0;
      div_load = 1'b0;
      div_en   = 1'b0;
      launch   = start && !cancel;

      case (state_q)
         MD_IDLE, MD_DONE: begin
            state_d = MD_IDLE;
            if (launch) begin
               op_d     = op_in;
               sa_d     = src_a[WIDTH-1];
               sb_d     = src_b[WIDTH-1];
               cnt_d    = '0;
               mcand_d  = a_mag;
               mul_hi_d = '0;
               mul_lo_d = b_mag;
               div_load = 1'b1;
               if (in_dbz) begin
                  state_d = MD_DONE;
                  hi_d    = src_a;
                  lo_d    = '1;
                  dbz_d   = 1'b1;
               end else if (!in_div && (MUL_ITER == 0)) begin
                  state_d      = MD_DONE;
                  {hi_d, lo_d} = fast_res;
               end else begin
                  state_d = MD_CALC;
               end
            end
         end
         MD_CALC: begin
            if (cancel) begin
               state_d = MD_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (md_is_div(op_q)) begin
                  div_en = 1'b1;
               end else begin
                  mul_hi_d = mul_hi_step;
                  mul_lo_d = mul_lo_step;
               end
               if (cnt_q == CNT_LAST) begin
                  state_d = MD_DONE;
                  if (md_is_div(op_q)) begin
                     hi_d = rem_neg ? -div_rem : div_rem;
                     lo_d = quo_neg ? -div_quo : div_quo;
                  end else begin
                     {hi_d, lo_d} = prod_res;
                  end
               end
            end
         end
         default: state_d = MD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= MD_IDLE;
         op_q     <= MD_MULT;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mul_hi_q <= '0;
         mul_lo_q <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mul_hi_q <= mul_hi_d;
         mul_lo_q <= mul_lo_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         dbz_q    <= dbz_d;
      end
   end

   assign busy        = (state_q == MD_CALC);
   assign done        = (state_q == MD_DONE);
   assign we_hi       = done;
   assign we_lo       = done;
   assign hi_out      = hi_q;
   assign lo_out      = lo_q;
   assign div_by_zero = dbz_q && done;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed corner cases plus random ops against an arithmetic reference model.
module tb_mul_div_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0, cancel = 1'b0;
   logic [1:0]   op = 2'b00;
   logic [W-1:0] src_a = '0, src_b = '0;
   logic         busy, done, we_hi, we_lo, div_by_zero;
   logic [W-1:0] hi_out, lo_out;

   logic         f_start = 1'b0, f_cancel = 1'b0;
   logic [1:0]   f_op = 2'b00;
   logic [W-1:0] f_a = '0, f_b = '0;
   logic         f_busy, f_done, f_we_hi, f_we_lo, f_dbz;
   logic [W-1:0] f_hi, f_lo;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a, b, hi, lo;
      int           lat;
      logic         dbz;
   } dir_vec_t;

   always #5 clk = ~clk;

   mul_div_unit #(.WIDTH(W), .MUL_ITER(1)) dut (
      .clk(clk), .rst(rst), .start(start), .cancel(cancel), .op(op),
      .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
      .we_hi(we_hi), .we_lo(we_lo), .hi_out(hi_out), .lo_out(lo_out),
      .div_by_zero(div_by_zero)
   );

   mul_div_unit #(.WIDTH(W), .MUL_ITER(0)) dut_fast (
      .clk(clk), .rst(rst), .start(f_start), .cancel(f_cancel), .op(f_op),
      .src_a(f_a), .src_b(f_b), .busy(f_busy), .done(f_done),
      .we_hi(f_we_hi), .we_lo(f_we_lo), .hi_out(f_hi), .lo_out(f_lo),
      .div_by_zero(f_dbz)
   );

   // Reference: plain 64-bit arithmetic, SV truncating division for signed ops.
   function automatic void ref_model(input logic [1:0] m_op, input logic [W-1:0] a, input logic [W-1:0] b,
                                     input bit fast, output logic [W-1:0] hi, output logic [W-1:0] lo,
                                     output logic dbz, output int lat);
      longint     sa, sb;
      logic [63:0] p;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      dbz = 1'b0;
      lat = 33;
      hi  = '0;
      lo  = '0;
      case (m_op)
         2'b00: begin p = 64'(sa * sb); {hi, lo} = p; if (fast) lat = 1; end
         2'b01: begin p = {32'b0, a} * {32'b0, b}; {hi, lo} = p; if (fast) lat = 1; end
         default: begin
            if (b == '0) begin
               hi = a; lo = '1; dbz = 1'b1; lat = 1;
            end else if (m_op == 2'b10) begin
               hi = 32'(sa % sb); lo = 32'(sa / sb);
            end else begin
               hi = a % b; lo = a / b;
            end
         end
      endcase
   endfunction

   function automatic logic [W-1:0] rand_operand();
      case ($urandom_range(0, 6))
         0: return 32'h8000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'($urandom_range(1, 20));
         3: return 32'd0;
         default: return 32'($urandom);
      endcase
   endfunction

   // Caller is at a negedge; start is sampled at the next posedge (cycle 0), returns in cycle 1.
   task automatic pulse_start(input bit fast, input logic [1:0] p_op, input logic [W-1:0] a, input logic [W-1:0] b);
      if (fast) begin f_start = 1'b1; f_op = p_op; f_a = a; f_b = b; end
      else begin start = 1'b1; op = p_op; src_a = a; src_b = b; end
      @(negedge clk);
      f_start = 1'b0;
      start   = 1'b0;
   endtask

   task automatic wait_done(input bit fast, input int first_cyc, output int done_cyc, output int busy_cnt);
      done_cyc = -1;
      busy_cnt = 0;
      for (int c = first_cyc; c <= first_cyc + 60; c++) begin
         if (fast ? f_busy : busy) busy_cnt++;
         if (fast ? f_done : done) begin done_cyc = c; break; end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({busy, done, we_hi, we_lo, div_by_zero} !== 5'b0) begin
         $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, we_hi, we_lo, div_by_zero}); miscompares++;
      end
      vectors++;
      if ({hi_out, lo_out} !== 64'h0) begin
         $display("FAIL reset_hilo: got %h expected 0", {hi_out, lo_out}); miscompares++;
      end
      vectors++;
      if ({f_busy, f_done, f_dbz, f_hi, f_lo} !== '0) begin
         $display("FAIL reset_fast: got %h expected 0", {f_busy, f_done, f_dbz, f_hi, f_lo}); miscompares++;
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      dir_vec_t vecs [5];
      int dc, bc;
      vecs[0] = '{op: 2'b00, a: 32'hFFFF_FFFE, b: 32'd3,         hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFA, lat: 33, dbz: 1'b0};
      vecs[1] = '{op: 2'b01, a: 32'hFFFF_FFFE, b: 32'd3,         hi: 32'h0000_0002, lo: 32'hFFFF_FFFA, lat: 33, dbz: 1'b0};
      vecs[2] = '{op: 2'b10, a: 32'hFFFF_FFF9, b: 32'd2,         hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD, lat: 33, dbz: 1'b0};
      vecs[3] = '{op: 2'b10, a: 32'h8000_0000, b: 32'hFFFF_FFFF, hi: 32'h0000_0000, lo: 32'h8000_0000, lat: 33, dbz: 1'b0};
      vecs[4] = '{op: 2'b11, a: 32'h0000_1234, b: 32'd0,         hi: 32'h0000_1234, lo: 32'hFFFF_FFFF, lat: 1,  dbz: 1'b1};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         pulse_start(1'b0, vecs[i].op, vecs[i].a, vecs[i].b);
         wait_done(1'b0, 1, dc, bc);
         vectors++;
         if (dc !== vecs[i].lat) begin
            $display("FAIL directed[%0d] done_cycle: got %0d expected %0d", i, dc, vecs[i].lat); miscompares++;
         end
         vectors++;
         if (bc !== vecs[i].lat - 1) begin
            $display("FAIL directed[%0d] busy_cycles: got %0d expected %0d", i, bc, vecs[i].lat - 1); miscompares++;
         end
         vectors++;
         if ({hi_out, lo_out} !== {vecs[i].hi, vecs[i].lo}) begin
            $display("FAIL directed[%0d] hi_lo: got %h expected %h", i, {hi_out, lo_out}, {vecs[i].hi, vecs[i].lo}); miscompares++;
         end
         vectors++;
         if ({we_hi, we_lo, div_by_zero} !== {2'b11, vecs[i].dbz}) begin
            $display("FAIL directed[%0d] we_dbz: got %b expected %b", i, {we_hi, we_lo, div_by_zero}, {2'b11, vecs[i].dbz}); miscompares++;
         end
         @(negedge clk);
         vectors++;
         if ({done, we_hi, we_lo, div_by_zero, busy} !== 5'b0) begin
            $display("FAIL directed[%0d] pulse_end: got %b expected 00000", i, {done, we_hi, we_lo, div_by_zero, busy}); miscompares++;
         end
      end
      // Same MULTU through the registered single-cycle multiplier.
      @(negedge clk);
      pulse_start(1'b1, 2'b01, 32'hFFFF_FFFE, 32'd3);
      wait_done(1'b1, 1, dc, bc);
      vectors++;
      if (dc !== 1 || bc !== 0) begin
         $display("FAIL fast_multu timing: got done %0d busy %0d expected done 1 busy 0", dc, bc); miscompares++;
      end
      vectors++;
      if ({f_hi, f_lo} !== 64'h0000_0002_FFFF_FFFA) begin
         $display("FAIL fast_multu hi_lo: got %h expected 00000002fffffffa", {f_hi, f_lo}); miscompares++;
      end
   endtask

   task automatic test_random();
      logic [1:0]   r_op;
      logic [W-1:0] a, b, e_hi, e_lo;
      logic         e_dbz;
      int           e_lat, dc, bc;
      for (int i = 0; i < 52; i++) begin
         bit fast;
         fast = (i >= 40);
         r_op = fast ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
         a    = rand_operand();
         b    = rand_operand();
         ref_model(r_op, a, b, fast, e_hi, e_lo, e_dbz, e_lat);
         @(negedge clk);
         pulse_start(fast, r_op, a, b);
         wait_done(fast, 1, dc, bc);
         vectors++;
         if (dc !== e_lat || bc !== e_lat - 1) begin
            $display("FAIL random[%0d] timing op=%0d: got done %0d busy %0d expected done %0d busy %0d",
                     i, r_op, dc, bc, e_lat, e_lat - 1);
            miscompares++;
         end
         vectors++;
         if (fast ? ({f_hi, f_lo, f_dbz} !== {e_hi, e_lo, e_dbz}) : ({hi_out, lo_out, div_by_zero} !== {e_hi, e_lo, e_dbz})) begin
            $display("FAIL random[%0d] result op=%0d a=%h b=%h: got %h_%h dbz %b expected %h_%h dbz %b", i, r_op, a, b,
                     fast ? f_hi : hi_out, fast ? f_lo : lo_out, fast ? f_dbz : div_by_zero, e_hi, e_lo, e_dbz);
            miscompares++;
         end
      end
   endtask

   task automatic test_cancel();
      logic [W-1:0] old_hi, old_lo, e_hi, e_lo, a, b;
      logic         e_dbz;
      int           e_lat, dc, bc, seen;
      @(negedge clk);
      old_hi = hi_out;
      old_lo = lo_out;
      pulse_start(1'b0, 2'b11, 32'($urandom) | 32'h1000, 32'd7);
      repeat (9) @(negedge clk);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      vectors++;
      if ({busy, done} !== 2'b00) begin
         $display("FAIL cancel_idle: got busy/done %b expected 00", {busy, done}); miscompares++;
      end
      seen = 0;
      repeat (40) begin
         if (done || we_lo || we_hi) seen++;
         @(negedge clk);
      end
      vectors++;
      if (seen !== 0 || {hi_out, lo_out} !== {old_hi, old_lo}) begin
         $display("FAIL cancel_nowrite: got %0d writes hi_lo %h expected 0 writes hi_lo %h", seen, {hi_out, lo_out}, {old_hi, old_lo});
         miscompares++;
      end
      // start and cancel together
      start = 1'b1; cancel = 1'b1; op = 2'b01; src_a = 32'h55; src_b = 32'h3;
      @(negedge clk);
      start = 1'b0; cancel = 1'b0;
      seen = 0;
      repeat (40) begin
         if (busy || done) seen++;
         @(negedge clk);
      end
      vectors++;
      if (seen !== 0 || {hi_out, lo_out} !== {old_hi, old_lo}) begin
         $display("FAIL start_cancel: got %0d active cycles hi_lo %h expected 0 and %h", seen, {hi_out, lo_out}, {old_hi, old_lo});
         miscompares++;
      end
      // start pulse while busy must neither relaunch nor re-latch operands
      a = 32'($urandom);
      b = 32'($urandom) | 32'h1;
      ref_model(2'b00, a, b, 1'b0, e_hi, e_lo, e_dbz, e_lat);
      pulse_start(1'b0, 2'b00, a, b);
      repeat (3) @(negedge clk);
      start = 1'b1; op = 2'b11; src_a = 32'($urandom); src_b = 32'd0;
      @(negedge clk);
      start = 1'b0;
      wait_done(1'b0, 5, dc, bc);
      vectors++;
      if (dc !== 33 || bc !== 28) begin
         $display("FAIL busy_start timing: got done %0d busy %0d expected done 33 busy 28", dc, bc); miscompares++;
      end
      vectors++;
      if ({hi_out, lo_out, div_by_zero} !== {e_hi, e_lo, 1'b0}) begin
         $display("FAIL busy_start result: got %h_%h dbz %b expected %h_%h dbz 0", hi_out, lo_out, div_by_zero, e_hi, e_lo);
         miscompares++;
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] a1, b1, a2, b2, e_hi, e_lo;
      logic         e_dbz;
      int           e_lat, dc, bc;
      a1 = 32'($urandom);
      b1 = 32'($urandom);
      a2 = 32'($urandom_range(1000, 100000));
      b2 = 32'hFFFF_FFF9;
      @(negedge clk);
      pulse_start(1'b0, 2'b01, a1, b1);
      wait_done(1'b0, 1, dc, bc);
      ref_model(2'b01, a1, b1, 1'b0, e_hi, e_lo, e_dbz, e_lat);
      vectors++;
      if (dc !== 33 || {hi_out, lo_out} !== {e_hi, e_lo}) begin
         $display("FAIL b2b_first: got done %0d %h expected done 33 %h", dc, {hi_out, lo_out}, {e_hi, e_lo}); miscompares++;
      end
      pulse_start(1'b0, 2'b10, a2, b2);
      wait_done(1'b0, 1, dc, bc);
      ref_model(2'b10, a2, b2, 1'b0, e_hi, e_lo, e_dbz, e_lat);
      vectors++;
      if (dc !== 33 || bc !== 32) begin
         $display("FAIL b2b_second timing: got done %0d busy %0d expected done 33 busy 32", dc, bc); miscompares++;
      end
      vectors++;
      if ({hi_out, lo_out} !== {e_hi, e_lo}) begin
         $display("FAIL b2b_second result: got %h expected %h", {hi_out, lo_out}, {e_hi, e_lo}); miscompares++;
      end
   endtask

   task automatic test_reset_mid_op();
      int seen;
      @(negedge clk);
      pulse_start(1'b0, 2'b00, 32'($urandom), 32'($urandom));
      repeat (4) @(negedge clk);
      rst = 1'b0;
      #1;
      vectors++;
      if ({busy, done, we_hi, we_lo, div_by_zero, hi_out, lo_out} !== '0) begin
         $display("FAIL reset_mid_op: got ctrl %b hi_lo %h expected all zero",
                  {busy, done, we_hi, we_lo, div_by_zero}, {hi_out, lo_out});
         miscompares++;
      end
      @(negedge clk);
      rst = 1'b1;
      seen = 0;
      repeat (40) begin
         if (done || busy) seen++;
         @(negedge clk);
      end
      vectors++;
      if (seen !== 0) begin
         $display("FAIL reset_no_done: got %0d active cycles expected 0", seen); miscompares++;
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_cancel();
      test_back_to_back();
      test_reset_mid_op();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
